// File: rtl/dmem_ctrl_if.sv
// Handshaked data-memory bus between dmem_ctrl (master) and the memory (slave).
interface dmem_ctrl_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );
    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Turns single-cycle MEM-stage load/store requests into handshaked bus transactions,
// stalling the pipeline until ack or timeout and returning extended load data.
module dmem_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    dmem_ctrl_if.master bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;

    logic          r_req, r_we, r_err;
    logic [31:0]   r_addr, r_wdata, r_data;
    logic [3:0]    r_be;
    logic [1:0]    r_off;
    logic [2:0]    r_f3;
    logic [CW-1:0] r_cnt;

    logic          w_byte, w_half, w_misalign, w_accept, w_tmo;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ld;
    logic [7:0]    w_rbyte;
    logic [15:0]   w_rhalf;

    // Request decode: anything that is not b/bu/h/hu is treated as a word access
    always_comb begin
        w_byte     = (funct3_i == 3'b000) || (funct3_i == 3'b100);
        w_half     = (funct3_i == 3'b001) || (funct3_i == 3'b101);
        w_misalign = (w_half && data_addr_i[0]) ||
                     (!w_byte && !w_half && (data_addr_i[1:0] != 2'b00));
        if (w_byte) begin
            w_be    = 4'b0001 << data_addr_i[1:0];
            w_wdata = {4{data_i[7:0]}};
        end else if (w_half) begin
            w_be    = data_addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{data_i[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = data_i;
        end
    end

    always_comb begin
        w_rbyte = bus.mem_rdata_i[{r_off, 3'b000} +: 8];
        w_rhalf = r_off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (r_f3)
            3'b000:  w_ld = {{24{w_rbyte[7]}}, w_rbyte};
            3'b100:  w_ld = {24'd0, w_rbyte};
            3'b001:  w_ld = {{16{w_rhalf[15]}}, w_rhalf};
            3'b101:  w_ld = {16'd0, w_rhalf};
            default: w_ld = bus.mem_rdata_i;
        endcase
    end

    // Ack on the final allowed cycle wins over the timeout
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1)) && !bus.mem_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: if (data_ce_i) begin
                if (w_misalign) begin
                    misalign_o = 1'b1;
                end else begin
                    stall_o  = 1'b1;
                    w_accept = 1'b1;
                    w_next   = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (bus.mem_ack_i || w_tmo) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req   <= 1'b1;
                r_we    <= data_we_i;
                r_addr  <= {data_addr_i[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_off   <= data_addr_i[1:0];
                r_f3    <= funct3_i;
                r_cnt   <= '0;
            end
            if (r_state == BUSY) begin
                if (bus.mem_ack_i) begin
                    r_req <= 1'b0;
                    if (!r_we) r_data <= w_ld;
                end else if (w_tmo) begin
                    r_req  <= 1'b0;
                    r_data <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (r_state == DONE) r_err <= 1'b0;
        end
    end

    assign data_o          = r_data;
    assign bus_err_o       = r_err;
    assign bus.mem_req_o   = r_req;
    assign bus.mem_we_o    = r_we;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_be_o    = r_be;
    assign bus.mem_wdata_o = r_wdata;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Random and directed load/store traffic against a spec-level reference model.
module tb_dmem_ctrl;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_ce_i = 1'b0, data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0, data_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        stall_o, misalign_o, bus_err_o;
    logic [31:0] data_o;

    int n_chk = 0, n_err = 0;
    logic [31:0] exp_data = '0;

    dmem_ctrl_if bus();

    dmem_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_i(data_i), .funct3_i(funct3_i),
        .stall_o(stall_o), .data_o(data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] s, v;
        s = w >> (8 * off);
        case (f3)
            3'd0: begin v = s & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
            3'd4: v = s & 32'hFF;
            3'd1: begin v = s & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
            3'd5: v = s & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // Called one time unit after a rising edge with the DUT in IDLE; returns likewise.
    // dly < T: ack after dly wait cycles; otherwise no ack (timeout).
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] d,
                          input logic [2:0] f3, input int dly, input logic [31:0] rdata);
        int sz, stalls;
        logic mis;
        logic [31:0] exp_be, exp_wd;
        logic [1:0] off;
        sz  = acc_size(f3);
        off = addr[1:0];
        mis = (sz == 2 && off[0]) || (sz == 4 && off != 2'd0);
        exp_be = (sz == 1) ? (32'd1 << off) : (sz == 2) ? ((off >= 2) ? 32'hC : 32'h3) : 32'hF;
        exp_wd = (sz == 1) ? (d & 32'hFF) * 32'h01010101 :
                 (sz == 2) ? (d & 32'hFFFF) * 32'h00010001 : d;
        data_ce_i = 1'b1; data_we_i = we; data_addr_i = addr; data_i = d; funct3_i = f3;
        @(negedge clk);
        chk("misalign", {31'd0, misalign_o}, {31'd0, mis});
        chk("stall_idle", {31'd0, stall_o}, {31'd0, !mis});
        if (mis) begin
            @(posedge clk); #1;
            data_ce_i = 1'b0;
            @(negedge clk);
            chk("req_misalign", {31'd0, bus.mem_req_o}, 32'd0);
            @(posedge clk); #1;
            return;
        end
        stalls = 1;
        @(posedge clk); #1;
        for (int w = 0; w < T; w++) begin
            bus.mem_ack_i   = (w == dly);
            bus.mem_rdata_i = (w == dly) ? rdata : $urandom;
            @(negedge clk);
            chk("req_busy", {31'd0, bus.mem_req_o}, 32'd1);
            if (stall_o) stalls++;
            if (w == 0) begin
                chk("we", {31'd0, bus.mem_we_o}, {31'd0, we});
                chk("addr", bus.mem_addr_o, {addr[31:2], 2'b00});
                chk("be", {28'd0, bus.mem_be_o}, exp_be);
                if (we) chk("wdata", bus.mem_wdata_o, exp_wd);
            end
            @(posedge clk); #1;
            bus.mem_ack_i = 1'b0;
            if (w == dly) break;
        end
        if (dly < T) begin
            if (!we) exp_data = ref_load(f3, off, rdata);
        end else begin
            exp_data = '0;
        end
        @(negedge clk);
        chk("stall_done", {31'd0, stall_o}, 32'd0);
        chk("req_done", {31'd0, bus.mem_req_o}, 32'd0);
        chk("data_o", data_o, exp_data);
        chk("bus_err", {31'd0, bus_err_o}, {31'd0, dly >= T});
        chk("stall_cycles", stalls, (dly < T) ? dly + 2 : T + 1);
        @(posedge clk); #1;
        data_ce_i = 1'b0;
    endtask

    initial begin
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_bus", {bus.mem_we_o, bus.mem_be_o, bus_err_o, misalign_o}, 32'd0);
        chk("rst_addr", bus.mem_addr_o | bus.mem_wdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF);
        chk("lw_const", data_o, 32'hDEADBEEF);
        access(1'b0, 32'h103, 32'h0, 3'b000, 1, 32'h80FF_0000);
        chk("lb_const", data_o, 32'hFFFFFF80);
        access(1'b0, 32'h103, 32'h0, 3'b100, 0, 32'h80FF_0000);
        chk("lbu_const", data_o, 32'h00000080);
        access(1'b0, 32'h102, 32'h0, 3'b001, 2, 32'h80FF_0000);
        chk("lh_const", data_o, 32'hFFFF80FF);
        access(1'b0, 32'h102, 32'h0, 3'b101, 0, 32'h80FF_0000);
        chk("lhu_const", data_o, 32'h000080FF);
        access(1'b1, 32'h201, 32'h12345678, 3'b000, 0, 32'h0);
        access(1'b1, 32'h202, 32'h12345678, 3'b001, 3, 32'h0);
        chk("store_holds", data_o, 32'h000080FF);
        access(1'b0, 32'h102, 32'h0, 3'b010, 0, 32'h0);
        access(1'b1, 32'h103, 32'h0, 3'b001, 0, 32'h0);
        access(1'b0, 32'h400, 32'h0, 3'b010, T, 32'h0);
        access(1'b0, 32'h404, 32'h0, 3'b010, 0, 32'hCAFEF00D);

        for (int i = 0; i < 80; i++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(7));
            access(1'($urandom), $urandom, $urandom, f3, $urandom_range(T + 1), $urandom);
            if ($urandom_range(3) == 0) begin
                bus.mem_ack_i = 1'b1;
                bus.mem_rdata_i = $urandom;
                @(negedge clk);
                chk("stray_ack_stall", {31'd0, stall_o}, 32'd0);
                @(posedge clk); #1;
                bus.mem_ack_i = 1'b0;
                @(negedge clk);
                chk("stray_ack_data", data_o, exp_data);
                @(posedge clk); #1;
            end
        end

        // Reset in the second BUSY cycle of a slow load
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h300; funct3_i = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        data_ce_i = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus.mem_req_o}, 32'd0);
        chk("arst_stall", {31'd0, stall_o}, 32'd0);
        exp_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = 32'h5A5A5A5A;
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        chk("late_ack_data", data_o, exp_data);
        chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 32'h500, 32'h0, 3'b010, 1, 32'h01234567);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
